// File: rtl/mrsw_ram_pkg.sv
// Shared definitions for the multi-read, single-write RAM.
package mrsw_ram_pkg;

   localparam int STYLE_RADDR = 0;   // registered read address, combinational data
   localparam int STYLE_RDATA = 1;   // registered read data, one cycle latency

   // Widest word the byte-merge helper handles; callers cast to and from this width.
   localparam int MAX_DATA_WIDTH = 256;
   localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

   // Byte merge: bytes with be[i]=1 come from new_word, the rest from old_word.
   function automatic logic [MAX_DATA_WIDTH-1:0] be_merge(
      input logic [MAX_DATA_WIDTH-1:0] old_word,
      input logic [MAX_DATA_WIDTH-1:0] new_word,
      input logic [MAX_BE_WIDTH-1:0]   be
   );
      logic [MAX_DATA_WIDTH-1:0] merged;
      merged = old_word;
      for (int i = 0; i < MAX_BE_WIDTH; i++) begin
         if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/mrsw_ram_rd_port.sv
// One read port of the RAM. Presents a word address to the array held in the top
// and turns the returned word into rdata, either through a registered address
// (data follows the array) or through a registered data word (value frozen at capture).
module mrsw_ram_rd_port
   import mrsw_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 2,
   parameter int READ_STYLE = STYLE_RADDR,
   parameter int RDW_NEW    = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ren,
   input  logic [ADDR_WIDTH-1:0]   raddr,
   input  logic                    wen,
   input  logic [DATA_WIDTH/8-1:0] wbe,
   input  logic [ADDR_WIDTH-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [ADDR_WIDTH-1:0]   arr_addr,
   input  logic [DATA_WIDTH-1:0]   arr_word,
   output logic [DATA_WIDTH-1:0]   rdata
);

   if (READ_STYLE == STYLE_RADDR) begin : g_raddr
      logic [ADDR_WIDTH-1:0] ra_q;
      logic [ADDR_WIDTH-1:0] ra_d;

      // Next read address: load on ren, otherwise hold
      always_comb begin
         // NOTE: assign a default first so every path drives ra_d and no latch is inferred.
         ra_d = ra_q;
         if (ren) ra_d = raddr;
      end

      // Address register; reset has priority so ren is ignored while rst is high
      always_ff @(posedge clk) begin
         // NOTE: sequential state uses non-blocking assignment so all flops update together.
         if (rst) ra_q <= '0;
         else     ra_q <= ra_d;
      end

      assign arr_addr = ra_q;
      assign rdata    = arr_word;

      // The write-side inputs only matter for the registered-data style.
      logic unused_wr;
      assign unused_wr = ^{wen, wbe, waddr, wdata};
   end else begin : g_rdata
      logic [DATA_WIDTH-1:0] rd_q;
      logic [DATA_WIDTH-1:0] rd_d;
      logic                  rdw_hit;

      // Next read data: capture the array word, or the post-write merge on a same-address write
      always_comb begin
         rdw_hit = (RDW_NEW != 0) && wen && (waddr == raddr);
         rd_d    = rd_q;
         if (ren) begin
            if (rdw_hit) begin
               rd_d = DATA_WIDTH'(be_merge(MAX_DATA_WIDTH'(arr_word),
                                           MAX_DATA_WIDTH'(wdata),
                                           MAX_BE_WIDTH'(wbe)));
            end else begin
               rd_d = arr_word;
            end
         end
      end

      // Data register; reset has priority so ren is ignored while rst is high
      always_ff @(posedge clk) begin
         if (rst) rd_q <= '0;
         else     rd_q <= rd_d;
      end

      assign arr_addr = raddr;
      assign rdata    = rd_q;
   end

endmodule

// File: rtl/mrsw_ram_rport.sv
// Multi-read, single-write RAM with a byte-enabled write port and NUM_RD independent
// read ports. The array lives here so it stays one memory; each port is a sub-module.
module mrsw_ram_rport
   import mrsw_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,           // multiple of 8, at most MAX_DATA_WIDTH
   parameter int ADDR_WIDTH = 2,
   parameter int NUM_RD     = 2,            // 1..8
   parameter int READ_STYLE = STYLE_RADDR,
   parameter int RDW_NEW    = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wen,
   input  logic [DATA_WIDTH/8-1:0]      wbe,
   input  logic [ADDR_WIDTH-1:0]        waddr,
   input  logic [DATA_WIDTH-1:0]        wdata,
   input  logic [NUM_RD-1:0]            ren,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
   output logic [NUM_RD*DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH    = 2 ** ADDR_WIDTH;
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  wr_fire;

   // A write is suppressed during reset
   always_comb begin
      wr_fire = wen & ~rst;
   end

   // Array write, byte granular
   always_ff @(posedge clk) begin
      // NOTE: the array is deliberately not reset; contents survive rst and it maps onto RAM.
      if (wr_fire) begin
         for (int b = 0; b < BE_WIDTH; b++) begin
            if (wbe[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_port
      logic [ADDR_WIDTH-1:0] port_addr;
      logic [DATA_WIDTH-1:0] port_word;

      assign port_word = mem_q[port_addr];

      mrsw_ram_rd_port #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .READ_STYLE (READ_STYLE),
         .RDW_NEW    (RDW_NEW)
      ) u_port (
         .clk      (clk),
         .rst      (rst),
         .ren      (ren[p]),
         .raddr    (raddr[p*ADDR_WIDTH +: ADDR_WIDTH]),
         .wen      (wen),
         .wbe      (wbe),
         .waddr    (waddr),
         .wdata    (wdata),
         .arr_addr (port_addr),
         .arr_word (port_word),
         .rdata    (rdata[p*DATA_WIDTH +: DATA_WIDTH])
      );
   end

endmodule

// File: tb/tb_mrsw_ram_rport.sv
// Bench for mrsw_ram_rport: three 4-port instances (RADDR, RDATA old-data, RDATA
// new-data) share one stimulus stream. Directed vectors carry hand-derived
// expectations; a gated-clock random run is checked against a behavioural model.
module tb_mrsw_ram_rport;

   localparam int DW = 32;
   localparam int AW = 2;
   localparam int NR = 4;

   localparam logic [31:0] Z    = 32'h0000_0000;
   localparam logic [31:0] W0   = 32'h0000_0A0A;
   localparam logic [31:0] DB   = 32'hDEAD_BEEF;
   localparam logic [31:0] MRG  = 32'h11BB_33DD;
   localparam logic [31:0] FULL = 32'h1122_3344;
   localparam logic [31:0] V55  = 32'h0000_0055;
   localparam logic [31:0] V66  = 32'h0000_0066;
   localparam logic [31:0] V12  = 32'h0000_1234;
   localparam logic [31:0] A0   = 32'hA0A0_A0A0;
   localparam logic [31:0] B1   = 32'hB1B1_B1B1;
   localparam logic [31:0] C2   = 32'hC2C2_C2C2;
   localparam logic [31:0] D3   = 32'hD3D3_D3D3;

   logic clk_free = 1'b0;
   logic run_en   = 1'b1;
   logic clk;
   assign clk = clk_free & run_en;
   always #5 clk_free = ~clk_free;

   logic          rst;
   logic          wen;
   logic [3:0]    wbe;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [NR-1:0] ren;
   logic [7:0]    raddr;
   logic [127:0]  rdata_ra, rdata_old, rdata_new;

   mrsw_ram_rport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .READ_STYLE(0), .RDW_NEW(0)) u_ra (
      .clk(clk), .rst(rst), .wen(wen), .wbe(wbe), .waddr(waddr), .wdata(wdata),
      .ren(ren), .raddr(raddr), .rdata(rdata_ra));
   mrsw_ram_rport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .READ_STYLE(1), .RDW_NEW(0)) u_old (
      .clk(clk), .rst(rst), .wen(wen), .wbe(wbe), .waddr(waddr), .wdata(wdata),
      .ren(ren), .raddr(raddr), .rdata(rdata_old));
   mrsw_ram_rport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .READ_STYLE(1), .RDW_NEW(1)) u_new (
      .clk(clk), .rst(rst), .wen(wen), .wbe(wbe), .waddr(waddr), .wdata(wdata),
      .ren(ren), .raddr(raddr), .rdata(rdata_new));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", name, act, exp);
   endtask

   // Compare every port selected by the masks, for all three instances.
   task automatic check_all(input string tag,
                            input logic [127:0] e_ra,  input logic [3:0] m_ra,
                            input logic [127:0] e_old, input logic [3:0] m_old,
                            input logic [127:0] e_new, input logic [3:0] m_new);
      for (int p = 0; p < NR; p++) begin
         if (m_ra[p])  check($sformatf("%s raddr p%0d", tag, p),  rdata_ra[p*32 +: 32],  e_ra[p*32 +: 32]);
         if (m_old[p]) check($sformatf("%s rd_old p%0d", tag, p), rdata_old[p*32 +: 32], e_old[p*32 +: 32]);
         if (m_new[p]) check($sformatf("%s rd_new p%0d", tag, p), rdata_new[p*32 +: 32], e_new[p*32 +: 32]);
      end
   endtask

   // Behavioural model of all three instances.
   logic [31:0]   m_mem [4];
   logic [AW-1:0] m_ra  [NR];
   logic [31:0]   m_old [NR];
   logic [31:0]   m_new [NR];

   task automatic model_edge();
      logic [AW-1:0] a;
      logic [31:0]   word, merged;
      if (rst) begin
         for (int p = 0; p < NR; p++) begin
            m_ra[p] = '0; m_old[p] = '0; m_new[p] = '0;
         end
      end else begin
         for (int p = 0; p < NR; p++) begin
            if (ren[p]) begin
               a      = raddr[2*p +: 2];
               word   = m_mem[a];
               merged = word;
               if (wen && waddr == a) begin
                  for (int b = 0; b < 4; b++) if (wbe[b]) merged[8*b +: 8] = wdata[8*b +: 8];
               end
               m_ra[p]  = a;
               m_old[p] = word;
               m_new[p] = merged;
            end
         end
         if (wen) begin
            for (int b = 0; b < 4; b++) if (wbe[b]) m_mem[waddr][8*b +: 8] = wdata[8*b +: 8];
         end
      end
   endtask

   typedef struct {
      logic [127:0] ra;
      logic [127:0] old_v;
      logic [127:0] new_v;
   } exp_t;

   exp_t sb_q[$];

   function automatic exp_t model_outputs();
      exp_t e;
      for (int p = 0; p < NR; p++) begin
         e.ra[p*32 +: 32]    = m_mem[m_ra[p]];
         e.old_v[p*32 +: 32] = m_old[p];
         e.new_v[p*32 +: 32] = m_new[p];
      end
      return e;
   endfunction

   // One real or gated clock period; the model only advances on a real edge.
   task automatic tick();
      if (run_en) model_edge();
      @(posedge clk_free);
      @(negedge clk_free);
   endtask

   typedef struct {
      logic          rst, wen;
      logic [3:0]    wbe;
      logic [AW-1:0] waddr;
      logic [31:0]   wdata;
      logic [3:0]    ren;
      logic [7:0]    raddr;
      logic [127:0]  e_ra, e_old, e_new;
      logic [3:0]    m_ra, m_old, m_new;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic w, input logic [3:0] be, input logic [AW-1:0] wa,
                               input logic [31:0] wd, input logic [3:0] re, input logic [7:0] ra,
                               input logic [127:0] e_ra, input logic [3:0] m_ra,
                               input logic [127:0] e_old, input logic [3:0] m_old,
                               input logic [127:0] e_new, input logic [3:0] m_new);
      vec_t v;
      v.rst = r; v.wen = w; v.wbe = be; v.waddr = wa; v.wdata = wd; v.ren = re; v.raddr = ra;
      v.e_ra = e_ra; v.m_ra = m_ra; v.e_old = e_old; v.m_old = m_old; v.e_new = e_new; v.m_new = m_new;
      return v;
   endfunction

   vec_t vecs [22];
   exp_t e;

   initial begin
      // Reset, persistence across reset, write ignored under reset
      vecs[0]  = mk(1, 0, 4'hF, 0, Z,            4'hF, 8'h00, '0, 4'h0, '0, 4'hF, '0, 4'hF);
      vecs[1]  = mk(1, 1, 4'hF, 0, 32'hCAFEF00D, 4'hF, 8'h00, '0, 4'h0, '0, 4'hF, '0, 4'hF);
      vecs[2]  = mk(0, 1, 4'hF, 0, W0,           4'h0, 8'h00, {4{W0}}, 4'hF, '0, 4'hF, '0, 4'hF);
      vecs[3]  = mk(0, 1, 4'hF, 1, DB,           4'h0, 8'h00, {4{W0}}, 4'hF, '0, 4'hF, '0, 4'hF);
      vecs[4]  = mk(1, 1, 4'hF, 1, Z,            4'hF, 8'h55, {4{W0}}, 4'hF, '0, 4'hF, '0, 4'hF);
      vecs[5]  = mk(0, 0, 4'h0, 0, Z,            4'h1, 8'h01, {W0, W0, W0, DB}, 4'hF, {Z, Z, Z, DB}, 4'hF, {Z, Z, Z, DB}, 4'hF);
      // Byte enables, with a same-address read on port 1
      vecs[6]  = mk(0, 1, 4'hF, 2, FULL,         4'h0, 8'h00, {Z, Z, Z, DB}, 4'h1, {Z, Z, Z, DB}, 4'h1, {Z, Z, Z, DB}, 4'h1);
      vecs[7]  = mk(0, 1, 4'h5, 2, 32'hAABBCCDD, 4'h2, 8'h08, {Z, Z, MRG, Z}, 4'h2, {Z, Z, FULL, Z}, 4'h2, {Z, Z, MRG, Z}, 4'h2);
      vecs[8]  = mk(0, 0, 4'h0, 0, Z,            4'h2, 8'h08, {Z, Z, MRG, Z}, 4'h2, {Z, Z, MRG, Z}, 4'h2, {Z, Z, MRG, Z}, 4'h2);
      // Read during write in both RDATA flavours, including a partial merge
      vecs[9]  = mk(0, 1, 4'hF, 3, Z,            4'h0, 8'h00, {Z, Z, MRG, Z}, 4'h2, {Z, Z, MRG, Z}, 4'h2, {Z, Z, MRG, Z}, 4'h2);
      vecs[10] = mk(0, 1, 4'h1, 3, V55,          4'h3, 8'h0F, {Z, Z, V55, V55}, 4'h3, {Z, Z, Z, Z}, 4'h3, {Z, Z, V55, V55}, 4'h3);
      vecs[11] = mk(0, 1, 4'h1, 3, 32'hFFFFFF66, 4'h4, 8'h30, {Z, V66, V66, V66}, 4'h7, {Z, V55, Z, Z}, 4'h4, {Z, V66, Z, Z}, 4'h4);
      // Address tracking versus held data; wbe=0 writes nothing
      vecs[12] = mk(0, 0, 4'h0, 0, Z,            4'h2, 8'h00, {Z, Z, W0, Z}, 4'h2, {Z, Z, W0, Z}, 4'h2, {Z, Z, W0, Z}, 4'h2);
      vecs[13] = mk(0, 1, 4'hF, 0, V12,          4'h0, 8'h00, {Z, Z, V12, Z}, 4'h2, {Z, Z, W0, Z}, 4'h2, {Z, Z, W0, Z}, 4'h2);
      vecs[14] = mk(0, 0, 4'h0, 0, Z,            4'h0, 8'h00, {Z, Z, V12, Z}, 4'h2, {Z, Z, W0, Z}, 4'h2, {Z, Z, W0, Z}, 4'h2);
      vecs[15] = mk(0, 1, 4'h0, 0, 32'hFFFFFFFF, 4'h0, 8'h00, {Z, Z, V12, Z}, 4'h2, {Z, Z, W0, Z}, 4'h2, {Z, Z, W0, Z}, 4'h2);
      // Multi-port: distinct words, then all ports on one address
      vecs[16] = mk(0, 1, 4'hF, 0, A0,           4'h0, 8'h00, '0, 4'h0, '0, 4'h0, '0, 4'h0);
      vecs[17] = mk(0, 1, 4'hF, 1, B1,           4'h0, 8'h00, '0, 4'h0, '0, 4'h0, '0, 4'h0);
      vecs[18] = mk(0, 1, 4'hF, 2, C2,           4'h0, 8'h00, '0, 4'h0, '0, 4'h0, '0, 4'h0);
      vecs[19] = mk(0, 1, 4'hF, 3, D3,           4'h0, 8'h00, '0, 4'h0, '0, 4'h0, '0, 4'h0);
      vecs[20] = mk(0, 0, 4'h0, 0, Z,            4'hF, 8'hE4, {D3, C2, B1, A0}, 4'hF, {D3, C2, B1, A0}, 4'hF, {D3, C2, B1, A0}, 4'hF);
      vecs[21] = mk(0, 0, 4'h0, 0, Z,            4'hF, 8'hAA, {4{C2}}, 4'hF, {4{C2}}, 4'hF, {4{C2}}, 4'hF);

      for (int i = 0; i < 22; i++) begin
         rst = vecs[i].rst; wen = vecs[i].wen; wbe = vecs[i].wbe; waddr = vecs[i].waddr;
         wdata = vecs[i].wdata; ren = vecs[i].ren; raddr = vecs[i].raddr;
         tick();
         check_all($sformatf("vec%0d", i), vecs[i].e_ra, vecs[i].m_ra,
                   vecs[i].e_old, vecs[i].m_old, vecs[i].e_new, vecs[i].m_new);
      end

      // Gated clock: active write and read requests must change nothing
      run_en = 1'b0;
      rst = 1'b0; wen = 1'b1; wbe = 4'hF; waddr = 2; wdata = Z; ren = 4'hF; raddr = 8'h00;
      for (int i = 0; i < 3; i++) tick();
      check_all("gated", {4{C2}}, 4'hF, {4{C2}}, 4'hF, {4{C2}}, 4'hF);
      run_en = 1'b1;
      wen = 1'b0; ren = 4'h0;
      tick();
      check_all("ungated", {4{C2}}, 4'hF, {4{C2}}, 4'hF, {4{C2}}, 4'hF);

      // Random traffic with a randomly gated clock, scored against the model
      for (int i = 0; i < 500; i++) begin
         run_en = ($urandom_range(0, 3) != 0);
         rst    = ($urandom_range(0, 39) == 0);
         wen    = 1'($urandom_range(0, 1));
         wbe    = 4'($urandom);
         waddr  = 2'($urandom);
         wdata  = $urandom;
         ren    = 4'($urandom);
         raddr  = 8'($urandom);
         if (run_en) model_edge();
         sb_q.push_back(model_outputs());
         @(posedge clk_free);
         @(negedge clk_free);
         e = sb_q.pop_front();
         check_all($sformatf("rnd%0d", i), e.ra, 4'hF, e.old_v, 4'hF, e.new_v, 4'hF);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
